// File: rtl/tick_time_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
package tick_time_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_PAIR_W  = 2 * BCD_DIGIT_W;

  localparam logic [BCD_PAIR_W-1:0] BCD_MAX_SS = 8'h59;
  localparam logic [BCD_PAIR_W-1:0] BCD_MAX_MM = 8'h59;
  localparam logic [BCD_PAIR_W-1:0] BCD_MAX_HH = 8'h23;

  // Both digits must be decimal; the numeric compare works once they are.
  function automatic logic bcd_in_range(input logic [BCD_PAIR_W-1:0] v,
                                        input logic [BCD_PAIR_W-1:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic [BCD_PAIR_W-1:0] bcd_inc(input logic [BCD_PAIR_W-1:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/tick_time_counter_if.sv
// Control, preset and time/status signals of tick_time_counter.
interface tick_time_counter_if;
  logic       clkm;
  logic       run;
  logic       load;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       sec_pulse;
  logic       day_wrap;
  logic       load_err;

  modport master (
    output clkm, run, load, set_hh, set_mm, set_ss,
    input  hh, mm, ss, sec_pulse, day_wrap, load_err
  );

  modport slave (
    input  clkm, run, load, set_hh, set_mm, set_ss,
    output hh, mm, ss, sec_pulse, day_wrap, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous preset; carry marks the wrap to 00.
module bcd_mod_counter
  import tick_time_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  load,
  input  logic [BCD_PAIR_W-1:0] load_val,
  input  logic [BCD_PAIR_W-1:0] max_val,
  output logic [BCD_PAIR_W-1:0] q,
  output logic                  carry
);

  logic [BCD_PAIR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = (q_q == max_val) ? '0 : bcd_inc(q_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && !load && (q_q == max_val);

endmodule

// File: rtl/tick_time_counter.sv
// Time-of-day clock: clkm edge detect, seconds prescaler, validated preset, BCD hh:mm:ss.
module tick_time_counter
  import tick_time_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 500
) (
  input  logic clk,
  input  logic reset,
  tick_time_counter_if.slave tt
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic          clkm_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_pulse_q, day_wrap_q, load_err_q;
  logic          tick, load_ok, load_bad, adv, sec_tick;
  logic          ss_carry, mm_carry, hh_carry;
  logic [7:0]    ss_q, mm_q, hh_q;

  assign tick     = tt.clkm & ~clkm_q;
  assign load_ok  = tt.load
                  & bcd_in_range(tt.set_ss, BCD_MAX_SS)
                  & bcd_in_range(tt.set_mm, BCD_MAX_MM)
                  & bcd_in_range(tt.set_hh, BCD_MAX_HH);
  assign load_bad = tt.load & ~load_ok;
  // A valid load swallows a coincident tick; a rejected one does not.
  assign adv      = tick & tt.run & ~load_ok;
  assign sec_tick = adv & (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (adv) begin
      presc_d = sec_tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkm_q      <= 1'b0;
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      clkm_q      <= tt.clkm;
      presc_q     <= presc_d;
      sec_pulse_q <= sec_tick;
      day_wrap_q  <= hh_carry;
      load_err_q  <= load_bad;
    end
  end

  bcd_mod_counter u_ss (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_tick),
    .load     (load_ok),
    .load_val (tt.set_ss),
    .max_val  (BCD_MAX_SS),
    .q        (ss_q),
    .carry    (ss_carry)
  );

  bcd_mod_counter u_mm (
    .clk      (clk),
    .reset    (reset),
    .inc      (ss_carry),
    .load     (load_ok),
    .load_val (tt.set_mm),
    .max_val  (BCD_MAX_MM),
    .q        (mm_q),
    .carry    (mm_carry)
  );

  bcd_mod_counter u_hh (
    .clk      (clk),
    .reset    (reset),
    .inc      (mm_carry),
    .load     (load_ok),
    .load_val (tt.set_hh),
    .max_val  (BCD_MAX_HH),
    .q        (hh_q),
    .carry    (hh_carry)
  );

  assign tt.ss        = ss_q;
  assign tt.mm        = mm_q;
  assign tt.hh        = hh_q;
  assign tt.sec_pulse = sec_pulse_q;
  assign tt.day_wrap  = day_wrap_q;
  assign tt.load_err  = load_err_q;

endmodule

// File: tb/tb_tick_time_counter.sv
// Directed bench for tick_time_counter with a short seconds prescaler.
module tb_tick_time_counter;

  localparam int unsigned TPS = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_sec    = 0;
  int   n_day    = 0;
  int   n_err    = 0;
  int   base_sec, base_err;

  tick_time_counter_if tt ();

  tick_time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk   (clk),
    .reset (reset),
    .tt    (tt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tt.sec_pulse) n_sec++;
    if (tt.day_wrap)  n_day++;
    if (tt.load_err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clkm_edges(input int n);
    for (int i = 0; i < n; i++) begin
      tt.clkm = 1'b1;
      step();
      tt.clkm = 1'b0;
      step();
    end
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    tt.set_hh = h;
    tt.set_mm = m;
    tt.set_ss = s;
    tt.load   = 1'b1;
    step();
    tt.load   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    tt.clkm   = 1'b0;
    tt.run    = 1'b0;
    tt.load   = 1'b0;
    tt.set_hh = '0;
    tt.set_mm = '0;
    tt.set_ss = '0;
    step();
    step();
    chk("rst_hh", tt.hh, 8'h00);
    chk("rst_mm", tt.mm, 8'h00);
    chk("rst_ss", tt.ss, 8'h00);
    chk("rst_flags", {tt.sec_pulse, tt.day_wrap, tt.load_err}, 3'b000);
    reset = 1'b0;
    step();

    // three seconds of counting
    tt.run   = 1'b1;
    base_sec = n_sec;
    clkm_edges(3 * TPS);
    chk("cnt3_ss", tt.ss, 8'h03);
    chk("cnt3_mm", tt.mm, 8'h00);
    chk("cnt3_pulses", n_sec - base_sec, 3);

    // day wrap
    do_load(8'h23, 8'h59, 8'h58);
    chk("ld_ok_err", tt.load_err, 1'b0);
    chk("ld_time", {tt.hh, tt.mm, tt.ss}, 24'h235958);
    clkm_edges(TPS);
    chk("pre_wrap", {tt.hh, tt.mm, tt.ss}, 24'h235959);
    chk("pre_wrap_day", n_day, 0);
    clkm_edges(TPS - 1);
    tt.clkm = 1'b1;
    step();
    chk("wrap_time", {tt.hh, tt.mm, tt.ss}, 24'h000000);
    chk("wrap_sec", tt.sec_pulse, 1'b1);
    chk("wrap_day", tt.day_wrap, 1'b1);
    tt.clkm = 1'b0;
    step();
    chk("wrap_pulses_1cyc", {tt.sec_pulse, tt.day_wrap}, 2'b00);

    // rejected loads
    base_err = n_err;
    do_load(8'h12, 8'h5A, 8'h00);
    chk("bad_mm_err", tt.load_err, 1'b1);
    do_load(8'h24, 8'h00, 8'h00);
    chk("bad_hh_err", tt.load_err, 1'b1);
    step();
    chk("bad_err_1cyc", tt.load_err, 1'b0);
    do_load(8'h00, 8'h00, 8'h60);
    step();
    chk("bad_err_count", n_err - base_err, 3);
    chk("bad_time_held", {tt.hh, tt.mm, tt.ss}, 24'h000000);

    // valid load coincident with the terminal tick
    do_load(8'h01, 8'h00, 8'h00);
    clkm_edges(TPS - 1);
    chk("pre_coin_presc", dut.presc_q, TPS - 1);
    base_sec  = n_sec;
    tt.set_hh = 8'h12;
    tt.set_mm = 8'h34;
    tt.set_ss = 8'h56;
    tt.clkm   = 1'b1;
    tt.load   = 1'b1;
    step();
    tt.load   = 1'b0;
    chk("coin_time", {tt.hh, tt.mm, tt.ss}, 24'h123456);
    chk("coin_presc", dut.presc_q, 0);
    chk("coin_sec", tt.sec_pulse, 1'b0);
    tt.clkm = 1'b0;
    step();
    chk("coin_pulses", n_sec - base_sec, 0);
    clkm_edges(TPS);
    chk("coin_resume", tt.ss, 8'h57);

    // rejected load coincident with the terminal tick
    clkm_edges(TPS - 1);
    tt.set_hh = 8'h3A;
    tt.clkm   = 1'b1;
    tt.load   = 1'b1;
    step();
    tt.load   = 1'b0;
    chk("bcoin_err", tt.load_err, 1'b1);
    chk("bcoin_sec", tt.sec_pulse, 1'b1);
    chk("bcoin_time", {tt.hh, tt.mm, tt.ss}, 24'h123458);
    tt.clkm = 1'b0;
    step();

    // freeze with run=0, resume from held prescaler
    clkm_edges(2);
    tt.run   = 1'b0;
    base_sec = n_sec;
    clkm_edges(5 * TPS);
    chk("frz_time", {tt.hh, tt.mm, tt.ss}, 24'h123458);
    chk("frz_presc", dut.presc_q, 2);
    chk("frz_pulses", n_sec - base_sec, 0);
    tt.run = 1'b1;
    clkm_edges(1);
    chk("resume_1", tt.ss, 8'h58);
    clkm_edges(1);
    chk("resume_2", tt.ss, 8'h59);
    clkm_edges(TPS);
    chk("mm_carry", {tt.hh, tt.mm, tt.ss}, 24'h123500);

    // hour carry across a units-9 hour
    base_sec = n_day;
    do_load(8'h09, 8'h59, 8'h59);
    clkm_edges(TPS);
    chk("hh_carry", {tt.hh, tt.mm, tt.ss}, 24'h100000);
    chk("hh_carry_noday", n_day - base_sec, 0);

    // asynchronous reset between clock edges
    clkm_edges(TPS - 1);
    tt.clkm = 1'b1;
    step();
    chk("prerst_sec", tt.sec_pulse, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_time", {tt.hh, tt.mm, tt.ss}, 24'h000000);
    chk("arst_flags", {tt.sec_pulse, tt.day_wrap, tt.load_err}, 3'b000);
    tt.clkm = 1'b0;
    step();
    reset    = 1'b0;
    base_sec = n_sec;
    step();
    step();
    chk("postrst_quiet", n_sec - base_sec, 0);
    clkm_edges(TPS);
    chk("postrst_count", tt.ss, 8'h01);
    chk("postrst_presc", dut.presc_q, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_time_counter.md
TICK_TIME_COUNTER -- requirements
Module: tick_time_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 500: the number of clkm rising edges that make one second.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its posedge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port clkm, input, 1 bit: divided clock from the upstream divider, synchronous to clk; it is sampled as data, never used as a clock.
REQ-005 The block SHALL have port run, input, 1 bit: 1 = count time, 0 = freeze.
REQ-006 The block SHALL have port load, input, 1 bit: one-cycle request to preset the time.
REQ-007 The block SHALL have ports set_hh, set_mm and set_ss, input, 8 bits each: BCD preset values for load.
REQ-008 The block SHALL have ports hh, mm and ss, output, 8 bits each: the current time in BCD, tens digit in bits [7:4].
REQ-009 The block SHALL have port sec_pulse, output, 1 bit: one-cycle pulse on each second increment.
REQ-010 The block SHALL have port day_wrap, output, 1 bit: one-cycle pulse on the 23:59:59 -> 00:00:00 transition.
REQ-011 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-012 The block SHALL register clkm into clkm_q every cycle and form tick = clkm AND NOT clkm_q: exactly one clk cycle per clkm rising edge.
REQ-013 The prescaler SHALL be ceil(log2(TICKS_PER_SEC)) bits wide and SHALL advance on tick only while run=1, counting 0..TICKS_PER_SEC-1.
REQ-014 A tick with the prescaler at TICKS_PER_SEC-1 SHALL wrap the prescaler to 0 and assert sec_pulse in the following cycle, with ss already updated in that same cycle.
REQ-015 ss SHALL count 00..59 in BCD; its wrap from 59 to 00 SHALL increment mm in the same cycle.
REQ-016 mm SHALL count 00..59 in BCD; its wrap from 59 to 00 SHALL increment hh in the same cycle.
REQ-017 hh SHALL count 00..23 in BCD; its wrap from 23 to 00 SHALL assert day_wrap together with sec_pulse.
REQ-018 Digit arithmetic SHALL be BCD: units digit 9 -> 0 with tens carry; results SHALL never contain a digit above 9.
REQ-019 With run=0, the prescaler and the time SHALL hold, ticks SHALL be discarded, and no sec_pulse SHALL be produced.
REQ-020 A load SHALL be valid only when every nibble is <=9, set_ss<=0x59, set_mm<=0x59 and set_hh<=0x23.
REQ-021 On a valid load, hh, mm and ss SHALL take the set values and the prescaler SHALL clear to 0 on the next edge.
REQ-022 A valid load SHALL take priority over a coincident tick: that tick is dropped, and no sec_pulse or day_wrap is produced.
REQ-023 An invalid load SHALL leave the time and prescaler unchanged and pulse load_err for one cycle; a coincident tick SHALL be processed normally.
REQ-024 load SHALL be honoured regardless of run.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 Asserting reset SHALL immediately force hh=mm=ss=0x00, prescaler=0, clkm_q=0, and sec_pulse=day_wrap=load_err=0.
REQ-027 Reset asserted mid-operation SHALL abort any count or load in progress; no pulse SHALL be emitted on deassertion.
REQ-028 After reset deassertion, counting SHALL resume from the first clkm rising edge sampled.

Structure
REQ-029 A shared package tick_time_pkg SHALL hold BCD_MAX_SS=8'h59, BCD_MAX_MM=8'h59, BCD_MAX_HH=8'h23 and the BCD digit width constant.
REQ-030 The two-digit BCD stage SHALL be a sub-module bcd_mod_counter with ports clk, reset, inc, load, load_val, max_val, q and carry.
REQ-031 bcd_mod_counter SHALL be instantiated three times, for ss, mm and hh.
REQ-032 The edge detector, prescaler, load validation and output pulse registers SHALL live in tick_time_counter.

Verification
REQ-033 Reset, then run=1 and 3*TICKS_PER_SEC clkm edges -> ss=0x03, mm=0x00, exactly 3 sec_pulse.
REQ-034 Load 23:59:58, then 2*TICKS_PER_SEC edges -> 23:59:59, then 00:00:00 with day_wrap and sec_pulse high in the same cycle.
REQ-035 load set_mm=0x5A, then set_hh=0x24 -> load_err pulses twice and the time is unchanged.
REQ-036 Valid load of 12:34:56 in the same cycle as the terminal tick -> time=12:34:56, prescaler=0, no sec_pulse.
REQ-037 run=0 for 5*TICKS_PER_SEC edges, then run=1 -> time frozen, then resumes from the held prescaler value.
REQ-038 Async reset mid-count, asserted off the clock edge -> outputs are zero before the next clk edge.
